// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, debug FSM
// states and default redirect constants.
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE         = 6'b000000;
  localparam logic [5:0] STALL_IF_ID        = 6'b000111;
  localparam logic [5:0] STALL_EX           = 6'b001111;
  localparam logic [5:0] STALL_MEM          = 6'b011111;
  localparam logic [5:0] STALL_FETCH_FREEZE = 6'b000011;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } dbg_state_e;

  // Deeper stages win: a MEM wait must also hold EX and everything before it.
  function automatic logic [5:0] merge_stall(input logic req_mem, input logic req_ex,
                                             input logic req_id, input logic req_if);
    if (req_mem)               return STALL_MEM;
    else if (req_ex)           return STALL_EX;
    else if (req_id || req_if) return STALL_IF_ID;
    else                       return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: merges stage stall requests, redirects on
// exceptions/ERET, runs the debug halt/single-step FSM and counts stall cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE    = ERET_CODE_DEF,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

  dbg_state_e    state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          halted_q, halted_d;

  logic [5:0] pstall;
  logic       exc;
  logic       freeze;

  always_comb begin
    pstall = merge_stall(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    exc    = (excepttype_i != 32'd0);
    freeze = (state_q == ST_DRAIN) || (state_q == ST_HALTED);

    flush  = !rst && exc;
    new_pc = 32'd0;
    if (flush) new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

    // An exception always wins so the redirect is never held off by a freeze.
    stall = pstall | (freeze ? STALL_FETCH_FREEZE : STALL_NONE);
    if (rst || exc) stall = STALL_NONE;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
          if (drain_cnt_q == DW'(1)) state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (step_req)      state_d = ST_STEP;
        else if (!halt_req) state_d = ST_RUN;
      end
      ST_STEP: begin
        // One instruction has left fetch once the PC advances without a flush.
        if (!pstall[0] && !flush) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      default: state_d = ST_RUN;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign halted = halted_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle expectations are queued by the driver and
// compared at the falling edge by the monitor.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic        halt_req, step_req;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halted;
  logic [3:0]  stall_cnt;

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EX   = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;
  localparam logic [5:0] FRZ    = 6'b000011;

  int vectors = 0;
  int errors  = 0;

  // entry: {rst, stall[5:0], flush, new_pc[31:0], halted}
  logic [40:0] exp_q[$];
  logic [40:0] mon_e;
  logic [3:0]  exp_cnt = 4'd0;

  pipeline_ctrl #(
    .DRAIN_CYCLES (4),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("stall",     32'(stall),     32'(mon_e[39:34]));
      check_eq("flush",     32'(flush),     32'(mon_e[33]));
      check_eq("new_pc",    new_pc,         mon_e[32:1]);
      check_eq("halted",    32'(halted),    32'(mon_e[0]));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      if (mon_e[40])                              exp_cnt = 4'd0;
      else if (mon_e[34] && (exp_cnt != 4'hF))    exp_cnt = exp_cnt + 4'd1;
    end
  end

  task automatic cyc(input logic r, input logic [3:0] req, input logic [31:0] exc,
                     input logic [31:0] epc, input logic h, input logic s,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic eh);
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    halt_req     = h;
    step_req     = s;
    exp_q.push_back({r, es, ef, ep, eh});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] req, input logic h, input logic s,
                     input logic [5:0] es, input logic eh);
    cyc(1'b0, req, 32'd0, 32'($urandom), h, s, es, 1'b0, 32'd0, eh);
  endtask

  logic [31:0] rnd_epc;

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = R_NONE;
    excepttype_i = 32'd0;
    cp0_epc_i    = 32'd0;
    halt_req     = 1'b0;
    step_req     = 1'b0;
    @(posedge clk);
    #1;

    // reset masks requests and exceptions
    cyc(1'b1, R_MEM, 32'h1, 32'h0, 1'b1, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, R_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0);

    // stall priority
    run(R_NONE,        0, 0, 6'b000000, 0);
    run(R_EX,          0, 0, 6'b001111, 0);
    run(R_EX | R_MEM,  0, 0, 6'b011111, 0);
    run(R_IF,          0, 0, 6'b000111, 0);
    run(R_ID,          0, 0, 6'b000111, 0);
    run(R_ID | R_EX,   0, 0, 6'b001111, 0);

    // exceptions and ERET
    rnd_epc = 32'($urandom_range(32'h0000_1000, 32'h7FFF_FFFF));
    cyc(0, R_MEM,  32'h1, rnd_epc,      0, 0, 6'b0, 1, 32'h0000_0020, 0);
    cyc(0, R_NONE, 32'hE, 32'h0000_1234, 0, 0, 6'b0, 1, 32'h0000_1234, 0);
    cyc(0, R_EX,   32'hE, rnd_epc,      0, 0, 6'b0, 1, rnd_epc,       0);
    cyc(0, R_ID,   32'h5, rnd_epc,      0, 0, 6'b0, 1, 32'h0000_0020, 0);

    // halt: 4 drain cycles then halted; release returns to RUN
    run(R_NONE, 1, 0, 6'b0, 0);
    repeat (4) run(R_NONE, 1, 0, FRZ, 0);
    run(R_NONE, 1, 0, FRZ, 1);
    run(R_ID,   1, 0, 6'b000111, 1);
    run(R_NONE, 0, 0, FRZ, 1);
    run(R_NONE, 0, 0, 6'b0, 0);

    // single step with ID stalling two cycles
    run(R_NONE, 1, 0, 6'b0, 0);
    repeat (4) run(R_NONE, 1, 0, FRZ, 0);
    run(R_NONE, 1, 1, FRZ, 1);
    run(R_ID,   1, 0, 6'b000111, 0);
    run(R_ID,   1, 0, 6'b000111, 0);
    run(R_NONE, 1, 0, 6'b0, 0);
    repeat (4) run(R_NONE, 1, 0, FRZ, 0);
    run(R_NONE, 1, 0, FRZ, 1);

    // step beats halt release; a flush keeps STEP from completing
    run(R_NONE, 0, 1, FRZ, 1);
    cyc(0, R_NONE, 32'h1, rnd_epc, 1, 0, 6'b0, 1, 32'h0000_0020, 0);
    run(R_NONE, 1, 0, 6'b0, 0);
    repeat (4) run(R_NONE, 1, 0, FRZ, 0);
    run(R_NONE, 1, 0, FRZ, 1);

    // release, then step_req is ignored in RUN
    run(R_NONE, 0, 0, FRZ, 1);
    run(R_NONE, 0, 1, 6'b0, 0);
    run(R_NONE, 0, 0, 6'b0, 0);

    // drain aborted by dropping halt_req
    run(R_NONE, 1, 0, 6'b0, 0);
    run(R_NONE, 0, 0, FRZ, 0);
    run(R_NONE, 0, 0, 6'b0, 0);

    // exception during drain: drain count still completes
    run(R_NONE, 1, 0, 6'b0, 0);
    run(R_NONE, 1, 0, FRZ, 0);
    cyc(0, R_MEM, 32'h1, rnd_epc, 1, 0, 6'b0, 1, 32'h0000_0020, 0);
    run(R_MEM,  1, 0, 6'b011111, 0);
    run(R_NONE, 1, 0, FRZ, 0);
    run(R_NONE, 1, 0, FRZ, 1);
    run(R_NONE, 0, 0, FRZ, 1);
    run(R_NONE, 0, 0, 6'b0, 0);

    // reset mid-drain
    run(R_NONE, 1, 0, 6'b0, 0);
    run(R_NONE, 1, 0, FRZ, 0);
    cyc(1, R_NONE, 32'h0, 32'h0, 1, 0, 6'b0, 0, 32'h0, 0);
    run(R_NONE, 0, 0, 6'b0, 0);

    // counter saturation at 4 bits
    repeat (20) run(R_EX, 0, 0, 6'b001111, 0);
    run(R_NONE, 0, 0, 6'b0, 0);
    check_eq("sat_final", 32'(stall_cnt), 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the 5-stage MIPS core. It merges stall requests from IF/ID/EX/MEM into the 6-bit `stall` vector consumed by pc_reg and the stage latches, and raises `flush` with a redirect `new_pc` when MEM reports an exception or ERET. It adds a debug halt/single-step FSM that freezes fetch and drains the pipeline. It also keeps a saturating stall-cycle performance counter.

## Interface

**Parameters**
- `EXC_VECTOR`, 32'h00000020: general exception entry address.
- `ERET_CODE`, 32'h0000000E: `excepttype_i` value meaning ERET.
- `DRAIN_CYCLES`, 4: cycles of fetch freeze before reporting halted; minimum 1.
- `CNT_W`, 32: stall counter width.

**Ports**
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous, active-high.
- `stallreq_if` input 1: IF requests stall (bus not ready).
- `stallreq_id` input 1: ID requests stall (load-use).
- `stallreq_ex` input 1: EX requests stall (multi-cycle div/madd).
- `stallreq_mem` input 1: MEM requests stall (data bus wait).
- `excepttype_i` input 32: MEM-stage exception type; 0 means none.
- `cp0_epc_i` input 32: current EPC from CP0.
- `halt_req` input 1: debug halt request; level-sensitive.
- `step_req` input 1: single-step pulse; honoured only in HALTED.
- `stall` output 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush` output 1: flush all stage latches this cycle.
- `new_pc` output 32: redirect address, valid when `flush`=1.
- `halted` output 1: registered; core is frozen and drained.
- `stall_cnt` output CNT_W: saturating count of cycles with `stall[0]`=1.

## Operation

- **Pipeline stall vector (`pstall`)**, fixed priority:
  - `stallreq_mem` gives 6'b011111.
  - else `stallreq_ex` gives 6'b001111.
  - else `stallreq_id` or `stallreq_if` gives 6'b000111.
  - else 6'b000000.
- **Exception**: `excepttype_i` != 0 forces `flush`=1 and `stall`=0, regardless of state or requests.
  - `new_pc` = `cp0_epc_i` if `excepttype_i` == `ERET_CODE`, else `EXC_VECTOR`.
  - When `flush`=0, `new_pc` = 0.
- **States**: RUN, DRAIN, HALTED, STEP. A down-counter `drain_cnt` (width clog2(DRAIN_CYCLES+1)) tracks drain progress.
  - **RUN**: `stall`=`pstall`. If `halt_req`=1, go to DRAIN and load `drain_cnt`=DRAIN_CYCLES.
  - **DRAIN**: `stall`=`pstall` | 6'b000011.
    - `halt_req`=0: go to RUN.
    - else decrement `drain_cnt`; when it is 1, go to HALTED.
  - **HALTED**: `stall`=`pstall` | 6'b000011.
    - `step_req`=1: go to STEP. Step has priority over `halt_req`=0 in the same cycle.
    - else `halt_req`=0: go to RUN.
  - **STEP**: `stall`=`pstall`. Stay until a cycle with `pstall[0]`=0 and `flush`=0 (one instruction fetched), then go to DRAIN with `drain_cnt` reloaded.
- A flush does not change FSM state. DRAIN keeps counting through a flush.
- `halted` = 1 exactly when the registered state is HALTED.
- `stall_cnt` increments each cycle `stall[0]`=1 in any state and saturates at all-ones.

## Timing

- `stall`, `flush`, `new_pc` are combinational from inputs and the registered state, with zero latency. pc_reg samples them at the next edge.
- `halt_req` is sampled at edge k: DRAIN during cycles k..k+DRAIN_CYCLES-1, HALTED and `halted`=1 from cycle k+DRAIN_CYCLES.
- `step_req` in HALTED at edge k: STEP at cycle k. It occupies at least one cycle, then DRAIN for DRAIN_CYCLES cycles, then HALTED.
- **Reset values**: state RUN, `drain_cnt`=0, `halted`=0, `stall_cnt`=0.
  - While `rst`=1, `stall`=0, `flush`=0, `new_pc`=0.
  - Reset mid-DRAIN or mid-STEP returns to RUN at the next cycle.

## Structure

- The shared defines header holds the stall encodings (STALL_NONE/IF_ID/EX/MEM/FETCH_FREEZE), the FSM state constants, and the default EXC_VECTOR/ERET_CODE.
- Use one sub-module, `sat_counter` (parameter W; inputs `inc`, `rst`; output `q`, saturating). It is reused by the other perf counters.

## Test plan

- Stall priority: `stallreq_ex`=1 gives `stall`=6'b001111. Adding `stallreq_mem`=1 gives 6'b011111. `stallreq_if` alone gives 6'b000111.
- Exception: `excepttype_i`=32'h1 with `stallreq_mem`=1 gives `flush`=1, `stall`=0, `new_pc`=32'h00000020. With `excepttype_i`=32'hE and `cp0_epc_i`=32'h00001234, `new_pc`=32'h00001234.
- Halt: `halt_req` set before edge 10 with DRAIN_CYCLES=4 gives `stall`=6'b000011 in cycles 10–13 and `halted`=1 from cycle 14. Dropping `halt_req` at edge 20 gives RUN and `halted`=0 at cycle 20.
- Step: `step_req` pulse while HALTED with `stallreq_id`=1 for 2 cycles gives STEP for 3 cycles and `stall[0]`=0 exactly once. Then `stall`=6'b000011 for 4 cycles, then `halted`=1.
- Saturation: CNT_W=4, `stallreq_ex` held for 20 cycles gives `stall_cnt`=15 and no wrap.
- Reset mid-operation: `rst` pulsed during DRAIN gives RUN, `stall_cnt`=0, `halted`=0 next cycle. An exception during DRAIN gives `flush`=1 while the drain count still completes.
